ula_multiciclo: RTL
===================

# ula_multiciclo

Execution-stage ALU that consumes the 5-bit `controle` code produced by the ALU control decoder, together with the two 32-bit operands, and produces a registered result plus a branch/compare flag. Logic, add/sub and compare operations complete in one cycle. Multiply and divide run on an iterative shift/add/subtract datapath with a start/busy/done handshake, so the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand and result width; iteration count equals `WIDTH`.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  operation request; sampled only while not busy.
- `controle`  in  5  operation code from the ALU control decoder.
- `A`, `B`  in  WIDTH  operands; signed two's complement; sampled with `start`.
- `resultado`  out  WIDTH  registered result.
- `flag`  out  1  registered branch/compare outcome.
- `div_zero`  out  1  registered; 1 when the last operation was a divide with B=0.
- `busy`  out  1  high while a multiply or divide is in progress.
- `done`  out  1  one-cycle pulse when `resultado`/`flag` are updated.

## Operation
- Codes:
  - 0 add; 1 sub; 2 mult; 3 div; 4 and; 5 or; 6 nand; 7 nor.
  - 8 beq; 9 bne; 10 bgt; 11 blt; 12 slt; 13 sle; 14 sge.
  - 30: `resultado`=B. 31: `resultado`=A. In both cases `flag`=0.
  - Any other code: `resultado`=0, `flag`=0, `done` still pulses.
- Add and sub wrap modulo 2^WIDTH; no overflow flag. Logic ops are bitwise. For these ops, and for codes 30 and 31, `flag`=0.
- Branches (8–11): `resultado`=A−B; `flag`=condition (signed compare for bgt/blt).
- Set ops (12–14): `resultado`={0…,cond}; `flag`=cond; signed compare.
- Mult: low WIDTH bits of the signed product. Computed as the product of magnitudes via shift-add, with the sign applied in the FIX state.
- Div: signed quotient truncated toward zero. Computed by restoring division on magnitudes, with the sign applied in the FIX state; the remainder is discarded.
- Div with B=0: no iteration. `resultado`=all ones, `div_zero`=1, `flag`=0. Single-cycle.
- FSM states: IDLE, MUL, DIV, FIX.
  - In IDLE, `start` with a single-cycle code: register result, stay in IDLE.
  - In IDLE, `start` with code 2 → MUL. With code 3 and B≠0 → DIV.
  - MUL and DIV each iterate WIDTH cycles, counter 0..WIDTH−1, then → FIX.
  - FIX applies the sign, registers the result, pulses `done`, → IDLE.
- `start` while `busy` is ignored; operands are captured only when `start` is accepted.
- `div_zero` is updated on every completed operation: 0 unless the div-by-zero case occurs.
- Outputs hold their last values between operations.

## Timing
- Reset, any time including mid-operation:
  - State IDLE, counter 0.
  - `resultado`=0, `flag`=0, `div_zero`=0, `busy`=0, `done`=0.
  - Any in-flight operation is aborted with no `done`.
- Single-cycle ops (including div by zero): `start` high in cycle N → `done`=1 and new outputs in cycle N+1. Back-to-back `start` every cycle is allowed.
- Mult and div: `start` in cycle N.
  - `busy`=1 in cycles N+1..N+33: iterations N+1..N+32, FIX N+33.
  - `done`=1 and outputs valid in cycle N+34, with `busy`=0.
  - A new `start` is accepted in cycle N+34.
- `done` is never high for two consecutive cycles belonging to the same operation.

## Structure
- Package `ula_pkg`: localparams for all controle codes (0–14, 30, 31), FSM state typedef, and the WIDTH default. The control decoder shares these constants.
- Sub-module `ula_muldiv`: iterative magnitude multiply/divide core.
  - Inputs: load, op, magnitudes.
  - Outputs: raw result, iteration-complete.
  - The top level holds the FSM, sign correction, single-cycle datapath and output registers.

## Test plan
- Reset asserted → all outputs 0. `start`, code 0, A=5, B=7 → `done` next cycle, `resultado`=12, `flag`=0.
- Code 11 (blt), A=−3, B=2 → `flag`=1, `resultado`=0xFFFFFFFB. Code 8, A=B=9 → `flag`=1, `resultado`=0.
- Code 2, A=−6, B=7 → `busy` cycles N+1..N+33, `done` at N+34, `resultado`=−42. A `start` issued at N+5 is ignored.
- Code 3, A=−43, B=5 → `resultado`=−8 at N+34. Code 3, B=0 → `done` at N+1, `resultado`=0xFFFFFFFF, `div_zero`=1.
- Reset pulsed at N+10 during a mult → no `done`, outputs 0. A `start` after release completes normally.
- Codes 30/31 with A=0x1234, B=0xABCD → 0xABCD / 0x1234. Code 20 → `resultado`=0, `done` pulses.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared constants for the execution-stage ALU and its control decoder:
// operation codes, FSM state encoding and the default datapath width.
package ula_pkg;

    localparam int ULA_WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MULT = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_NAND = 5'd6;
    localparam logic [4:0] OP_NOR  = 5'd7;
    localparam logic [4:0] OP_BEQ  = 5'd8;
    localparam logic [4:0] OP_BNE  = 5'd9;
    localparam logic [4:0] OP_BGT  = 5'd10;
    localparam logic [4:0] OP_BLT  = 5'd11;
    localparam logic [4:0] OP_SLT  = 5'd12;
    localparam logic [4:0] OP_SLE  = 5'd13;
    localparam logic [4:0] OP_SGE  = 5'd14;
    localparam logic [4:0] OP_PASSB = 5'd30;
    localparam logic [4:0] OP_PASSA = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

endpackage

// File: rtl/ula_muldiv.sv
// Iterative unsigned core: shift-add multiply (low half) or restoring divide
// (quotient), one step per cycle for WIDTH cycles after load.
module ula_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             op,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] raw,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);

    logic             active;
    logic             op_q;
    logic [CW-1:0]    cnt;
    // hi: accumulator (mul) or partial remainder (div)
    // lo: multiplier (mul) or dividend/quotient (div); b: shifted multiplicand or divisor
    logic [WIDTH-1:0] hi, lo, b;
    logic [WIDTH:0]   shifted, trial;

    assign shifted = {hi, lo[WIDTH-1]};
    assign trial   = shifted - {1'b0, b};
    assign last    = active && (cnt == CW'(WIDTH - 1));
    assign raw     = op_q ? lo : hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            op_q   <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            b      <= '0;
        end else if (load) begin
            active <= 1'b1;
            op_q   <= op;
            cnt    <= '0;
            hi     <= '0;
            lo     <= a_mag;
            b      <= b_mag;
        end else if (active) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) active <= 1'b0;
            if (op_q) begin
                if (!trial[WIDTH]) begin
                    hi <= trial[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= shifted[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (lo[0]) hi <= hi + b;
                b  <= b << 1;
                lo <= lo >> 1;
            end
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Execution-stage ALU: single-cycle logic/arith/compare ops plus a multicycle
// signed multiply/divide built on the magnitude core, with sign fixed up at the end.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       controle,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] resultado,
    output logic             flag,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);
    state_t           state, state_nxt;
    logic             load, op_div, neg_q;
    logic [WIDTH-1:0] a_mag, b_mag, raw;
    logic             core_last;

    logic [WIDTH-1:0] sc_res, diff;
    logic             sc_flag, sc_dz, lt, eq;

    assign a_mag  = A[WIDTH-1] ? -A : A;
    assign b_mag  = B[WIDTH-1] ? -B : B;
    assign op_div = (controle == OP_DIV);
    assign busy   = (state != S_IDLE);

    ula_muldiv #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .op    (op_div),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .raw   (raw),
        .last  (core_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && controle == OP_MULT) begin
                    state_nxt = S_MUL;
                    load      = 1'b1;
                end else if (start && op_div && B != '0) begin
                    state_nxt = S_DIV;
                    load      = 1'b1;
                end
            end
            S_MUL, S_DIV: if (core_last) state_nxt = S_FIX;
            S_FIX:        state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    assign diff = A - B;
    assign lt   = $signed(A) < $signed(B);
    assign eq   = (A == B);

    always_comb begin
        sc_res  = '0;
        sc_flag = 1'b0;
        sc_dz   = 1'b0;
        case (controle)
            OP_ADD:   sc_res = A + B;
            OP_SUB:   sc_res = diff;
            OP_AND:   sc_res = A & B;
            OP_OR:    sc_res = A | B;
            OP_NAND:  sc_res = ~(A & B);
            OP_NOR:   sc_res = ~(A | B);
            OP_BEQ:   begin sc_res = diff; sc_flag = eq;         end
            OP_BNE:   begin sc_res = diff; sc_flag = !eq;        end
            OP_BGT:   begin sc_res = diff; sc_flag = !lt && !eq; end
            OP_BLT:   begin sc_res = diff; sc_flag = lt;         end
            OP_SLT:   begin sc_res = {{(WIDTH-1){1'b0}}, lt};         sc_flag = lt;         end
            OP_SLE:   begin sc_res = {{(WIDTH-1){1'b0}}, lt || eq};   sc_flag = lt || eq;   end
            OP_SGE:   begin sc_res = {{(WIDTH-1){1'b0}}, !lt};        sc_flag = !lt;        end
            OP_PASSB: sc_res = B;
            OP_PASSA: sc_res = A;
            // only reached in the single-cycle path when B is zero
            OP_DIV:   begin sc_res = '1; sc_dz = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q     <= 1'b0;
            resultado <= '0;
            flag      <= 1'b0;
            div_zero  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            end else if (state == S_IDLE && start) begin
                resultado <= sc_res;
                flag      <= sc_flag;
                div_zero  <= sc_dz;
                done      <= 1'b1;
            end else if (state == S_FIX) begin
                resultado <= neg_q ? -raw : raw;
                flag      <= 1'b0;
                div_zero  <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule
